fib_write_checker: RTL and testbench

Synthesizable, parametrised self-check monitor for the single-cycle ARM core running the Fibonacci program. Sits beside `top` and snoops the data-memory write port (`MemWrite`, `DataAdr`, `WriteData`). It compares qualifying stores against an internally generated Fibonacci sequence and reports pass, fail or timeout on status outputs. Board-level runs therefore need no simulator-side checking.

---
 rtl/fib_check_pkg.sv | 28 ++
 rtl/fib_gen.sv | 39 +++
 rtl/fib_write_checker.sv | 128 ++++++++++++
 tb/tb_fib_write_checker.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_check_pkg.sv
// Shared types and constants for the Fibonacci store checker.
package fib_check_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PASS,
      ST_FAIL
   } fib_state_t;

   // F(n) mod 2^width with F(1)=F(2)=1; evaluated at elaboration time.
   function automatic logic [63:0] fib_term(input int unsigned n, input int unsigned width);
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] t;
      logic [63:0] mask;
      mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      a = 64'd1;
      b = 64'd1;
      for (int unsigned i = 1; i < n; i++) begin
         t = (a + b) & mask;
         a = b;
         b = t;
      end
      return a & mask;
   endfunction

endpackage

// File: rtl/fib_gen.sv
// Running Fibonacci pair generator: term is F(k), the next expected value.
module fib_gen #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             advance,
   output logic [WIDTH-1:0] term
);

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;

   always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (load) begin
         a_d = WIDTH'(1);
         b_d = WIDTH'(1);
      end else if (advance) begin
         a_d = b_q;
         b_d = a_q + b_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= WIDTH'(1);
         b_q <= WIDTH'(1);
      end else begin
         a_q <= a_d;
         b_q <= b_d;
      end
   end

   assign term = a_q;

endmodule

// File: rtl/fib_write_checker.sv
// Snoops the core's data-memory write port and checks stores against the
// Fibonacci sequence, reporting pass / fail / timeout from registered state.
module fib_write_checker
   import fib_check_pkg::*;
#(
   parameter int unsigned      WIDTH      = 32,
   parameter int unsigned      NUM_TERMS  = 10,
   parameter logic [WIDTH-1:0] ADDR_MATCH = '0,
   parameter logic [WIDTH-1:0] ADDR_MASK  = '0,
   parameter bit               STRICT     = 1'b1,
   parameter int unsigned      TIMEOUT    = 4096
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             MemWrite,
   input  logic [WIDTH-1:0]                 DataAdr,
   input  logic [WIDTH-1:0]                 WriteData,
   output logic                             busy,
   output logic                             done,
   output logic                             pass,
   output logic                             fail,
   output logic                             timed_out,
   output logic [$clog2(NUM_TERMS+1)-1:0]   term_idx,
   output logic [WIDTH-1:0]                 err_data
);

   localparam int unsigned      IW    = $clog2(NUM_TERMS + 1);
   localparam int unsigned      CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IW-1:0]    NT    = IW'(NUM_TERMS);
   localparam logic [CW-1:0]    TO    = CW'(TIMEOUT);
   localparam logic [WIDTH-1:0] FINAL = WIDTH'(fib_term(NUM_TERMS, WIDTH));

   fib_state_t       state_q, state_d;
   logic [IW-1:0]    term_idx_q, term_idx_d;
   logic [WIDTH-1:0] err_q, err_d;
   logic             to_q, to_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             gen_load, gen_adv;
   logic [WIDTH-1:0] term;
   logic             qual, match, complete, mismatch, timeout_hit;
   logic [IW-1:0]    term_inc;
   logic [CW-1:0]    cnt_inc;

   fib_gen #(.WIDTH(WIDTH)) u_gen (
      .clk     (clk),
      .rst_n   (reset),
      .load    (gen_load),
      .advance (gen_adv),
      .term    (term)
   );

   assign qual        = (state_q == ST_RUN) && MemWrite &&
                        ((DataAdr & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK));
   assign match       = STRICT ? (WriteData == term) : (WriteData == FINAL);
   assign term_inc    = term_idx_q + IW'(1);
   assign cnt_inc     = cnt_q + CW'(1);
   assign complete    = qual && match && (STRICT ? (term_inc == NT) : 1'b1);
   assign mismatch    = qual && STRICT && !match;
   assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         term_idx_q <= '0;
         err_q      <= '0;
         to_q       <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         term_idx_q <= term_idx_d;
         err_q      <= err_d;
         to_q       <= to_d;
         cnt_q      <= cnt_d;
      end
   end

   // A completing write outranks a timeout landing on the same edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (complete)                    state_d = ST_PASS;
            else if (mismatch || timeout_hit) state_d = ST_FAIL;
         end
         default: begin
            if (start) state_d = ST_RUN;
         end
      endcase
   end

   always_comb begin
      term_idx_d = term_idx_q;
      err_d      = err_q;
      to_d       = to_q;
      cnt_d      = cnt_q;
      gen_load   = 1'b0;
      gen_adv    = 1'b0;
      if (state_q != ST_RUN) begin
         if (start) begin
            term_idx_d = '0;
            err_d      = '0;
            to_d       = 1'b0;
            cnt_d      = '0;
            gen_load   = 1'b1;
         end
      end else begin
         cnt_d = cnt_inc;
         if (qual && (STRICT ? match : (term_idx_q != NT))) term_idx_d = term_inc;
         gen_adv = qual && STRICT && match;
         if (mismatch)                      err_d = WriteData;
         else if (timeout_hit && !complete) to_d  = 1'b1;
      end
   end

   always_comb begin
      busy = (state_q == ST_RUN);
      pass = (state_q == ST_PASS);
      fail = (state_q == ST_FAIL);
      done = pass || fail;
   end

   assign timed_out = to_q;
   assign term_idx  = term_idx_q;
   assign err_data  = err_q;

endmodule

// File: tb/tb_fib_write_checker.sv
// Bench for fib_write_checker: four configurations share one write bus and
// are started one at a time; expectations come from plain Fibonacci arithmetic.
module tb_fib_write_checker;

   localparam logic [3:0] F_IDLE = 4'b0000;  // {busy, done, pass, fail}
   localparam logic [3:0] F_RUN  = 4'b1000;
   localparam logic [3:0] F_PASS = 4'b0110;
   localparam logic [3:0] F_FAIL = 4'b0101;

   logic        clk;
   logic        reset;
   logic [3:0]  start_v;
   logic        mem_write;
   logic [31:0] data_adr;
   logic [31:0] write_data;

   logic [3:0]  busy_v, done_v, pass_v, fail_v, to_v;
   logic [3:0]  ti0, ti1, ti2, ti3;
   logic [31:0] ed0, ed1, ed2;
   logic [7:0]  ed3;

   int checks;
   int errors;
   int p, n, cyc;
   logic [31:0] bad;
   logic [31:0] v;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fib_write_checker u_def (
      .clk(clk), .reset(reset), .start(start_v[0]), .MemWrite(mem_write),
      .DataAdr(data_adr), .WriteData(write_data),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]),
      .timed_out(to_v[0]), .term_idx(ti0), .err_data(ed0)
   );

   fib_write_checker #(.ADDR_MASK(32'hFFFF_FFFC), .ADDR_MATCH(32'h64)) u_mask (
      .clk(clk), .reset(reset), .start(start_v[1]), .MemWrite(mem_write),
      .DataAdr(data_adr), .WriteData(write_data),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]),
      .timed_out(to_v[1]), .term_idx(ti1), .err_data(ed1)
   );

   fib_write_checker #(.STRICT(1'b0), .TIMEOUT(50)) u_loose (
      .clk(clk), .reset(reset), .start(start_v[2]), .MemWrite(mem_write),
      .DataAdr(data_adr), .WriteData(write_data),
      .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .fail(fail_v[2]),
      .timed_out(to_v[2]), .term_idx(ti2), .err_data(ed2)
   );

   fib_write_checker #(.WIDTH(8), .NUM_TERMS(14)) u_w8 (
      .clk(clk), .reset(reset), .start(start_v[3]), .MemWrite(mem_write),
      .DataAdr(data_adr[7:0]), .WriteData(write_data[7:0]),
      .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .fail(fail_v[3]),
      .timed_out(to_v[3]), .term_idx(ti3), .err_data(ed3)
   );

   function automatic logic [31:0] fib_ref(input int k, input int w);
      longint unsigned a, b, t, mask;
      mask = (64'd1 << w) - 64'd1;
      a = 1;
      b = 1;
      for (int i = 1; i < k; i++) begin
         t = (a + b) & mask;
         a = b;
         b = t;
      end
      return 32'(a & mask);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 3)) tick();
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
      mem_write  = 1'b1;
      data_adr   = adr;
      write_data = dat;
      tick();
      mem_write  = 1'b0;
      data_adr   = $urandom;
      write_data = $urandom;
   endtask

   task automatic start_dut(input int d);
      start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check(input string tag, input int d, input logic [3:0] ef,
                        input int eti, input logic [31:0] eed, input logic eto);
      logic [3:0]  ti;
      logic [31:0] ed;
      case (d)
         0:       begin ti = ti0; ed = ed0; end
         1:       begin ti = ti1; ed = ed1; end
         2:       begin ti = ti2; ed = ed2; end
         default: begin ti = ti3; ed = {24'd0, ed3}; end
      endcase
      chk({tag, ".flags"}, {28'd0, busy_v[d], done_v[d], pass_v[d], fail_v[d]}, {28'd0, ef});
      chk({tag, ".term_idx"}, {28'd0, ti}, 32'(eti));
      chk({tag, ".err_data"}, ed, eed);
      chk({tag, ".timed_out"}, {31'd0, to_v[d]}, {31'd0, eto});
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b0;
      start_v    = '0;
      mem_write  = 1'b0;
      data_adr   = '0;
      write_data = '0;
      repeat (2) tick();
      for (int d = 0; d < 4; d++) check("reset", d, F_IDLE, 0, 0, 1'b0);
      reset = 1'b1;
      tick();

      // default config, full correct sequence with random gaps and addresses
      start_dut(0);
      check("strict.start", 0, F_RUN, 0, 0, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         gap();
         wr($urandom, fib_ref(k, 32));
         check("strict.term", 0, (k == 10) ? F_PASS : F_RUN, k, 0, 1'b0);
      end
      wr(32'h0, 32'd77);
      check("strict.hold", 0, F_PASS, 10, 0, 1'b0);

      // restart with a write in the start cycle (must be ignored), then 1,1,2,4
      mem_write  = 1'b1;
      write_data = 32'd999;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      mem_write  = 1'b0;
      check("mis.start", 0, F_RUN, 0, 0, 1'b0);
      wr(32'h0, 32'd1);
      wr(32'h0, 32'd1);
      wr(32'h0, 32'd2);
      check("mis.pre", 0, F_RUN, 3, 0, 1'b0);
      wr(32'h0, 32'd4);
      check("mis.fail", 0, F_FAIL, 3, 32'd4, 1'b0);
      wr(32'h0, 32'd3);
      check("mis.hold", 0, F_FAIL, 3, 32'd4, 1'b0);

      // random mismatch position and value
      p   = $urandom_range(1, 10);
      bad = fib_ref(p, 32) + $urandom_range(1, 1000);
      start_dut(0);
      for (int k = 1; k < p; k++) wr($urandom, fib_ref(k, 32));
      wr($urandom, bad);
      check("mis.rand", 0, F_FAIL, p - 1, bad, 1'b0);

      // address-qualified config: 0x60..0x63 carrying 99 must be ignored
      start_dut(1);
      for (int k = 1; k <= 10; k++) begin
         repeat ($urandom_range(0, 2)) wr(32'h60 | 32'($urandom_range(0, 3)), 32'd99);
         check("mask.noise", 1, F_RUN, k - 1, 0, 1'b0);
         wr(32'h64 | 32'($urandom_range(0, 3)), fib_ref(k, 32));
         check("mask.term", 1, (k == 10) ? F_PASS : F_RUN, k, 0, 1'b0);
      end

      // non-strict: any values counted, final term passes
      start_dut(2);
      wr($urandom, 32'd7);
      check("loose.w7", 2, F_RUN, 1, 0, 1'b0);
      wr($urandom, 32'd9);
      check("loose.w9", 2, F_RUN, 2, 0, 1'b0);
      wr($urandom, 32'd55);
      check("loose.pass", 2, F_PASS, 3, 0, 1'b0);

      // non-strict timeout exactly 50 cycles after busy rose, with saturation
      start_dut(2);
      cyc = 0;
      n   = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
         v = 32'($urandom_range(0, 54));
         wr($urandom, v);
         cyc++;
         check("loose.count", 2, F_RUN, (i + 1 > 10) ? 10 : i + 1, 0, 1'b0);
      end
      while (cyc < 49) begin
         tick();
         cyc++;
      end
      check("loose.pre_to", 2, F_RUN, (n > 10) ? 10 : n, 0, 1'b0);
      tick();
      check("loose.timeout", 2, F_FAIL, (n > 10) ? 10 : n, 0, 1'b1);

      // completing write on the timeout edge wins
      start_dut(2);
      repeat (49) tick();
      wr($urandom, 32'd55);
      check("loose.race", 2, F_PASS, 1, 0, 1'b0);

      // 8-bit wrap: term 14 is 377 mod 256
      start_dut(3);
      for (int k = 1; k <= 14; k++) begin
         wr($urandom, fib_ref(k, 8));
         check("w8.term", 3, (k == 14) ? F_PASS : F_RUN, k, 0, 1'b0);
      end
      start_dut(3);
      for (int k = 1; k <= 13; k++) wr($urandom, fib_ref(k, 8));
      bad = {24'd0, 8'(fib_ref(14, 8) + 32'($urandom_range(1, 255)))};
      wr($urandom, bad);
      check("w8.fail", 3, F_FAIL, 13, bad, 1'b0);

      // mismatching write on the timeout edge: data failure, not timeout
      start_dut(0);
      repeat (4095) tick();
      wr($urandom, 32'd5);
      check("strict.race", 0, F_FAIL, 0, 32'd5, 1'b0);

      // asynchronous reset mid-run
      start_dut(0);
      for (int k = 1; k <= 3; k++) wr($urandom, fib_ref(k, 32));
      check("rst.pre", 0, F_RUN, 3, 0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      for (int d = 0; d < 4; d++) check("rst.async", d, F_IDLE, 0, 0, 1'b0);
      #2;
      reset = 1'b1;
      tick();
      check("rst.after", 0, F_IDLE, 0, 0, 1'b0);
      start_dut(0);
      for (int k = 1; k <= 10; k++) wr($urandom, fib_ref(k, 32));
      check("rst.pass", 0, F_PASS, 10, 0, 1'b0);
      start_dut(0);
      check("rst.restart", 0, F_RUN, 0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
